// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared FSM encodings and AXI4-Lite response codes
// Purpose: state encodings for the arbiter FSM and AXI response codes.
// Ports: none (package).
package axi_lite_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_WRESP = 3'd2;
    localparam logic [2:0] ST_RADDR = 3'd3;
    localparam logic [2:0] ST_RDATA = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        WRITE = ST_WRITE,
        WRESP = ST_WRESP,
        RADDR = ST_RADDR,
        RDATA = ST_RDATA,
        DONE  = ST_DONE
    } state_e;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_arbiter_if.sv
// rtl/axi_lite_arbiter_if.sv - AXI4-Lite bus bundle with master/slave views
// Purpose: groups the five AXI4-Lite channels of the shared master port.
// Ports: aw*/w*/b* write channels, ar*/r* read channels;
//        master modport drives valids/payload, slave modport drives readies/responses.
interface axi_lite_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import axi_lite_pkg::*;

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    resp_t                   bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    resp_t                   rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_arbiter_rr_arb2.sv
// rtl/axi_lite_arbiter_rr_arb2.sv - combinational two-way round-robin pick
// Purpose: chooses one of two requesters; on a tie the one not granted last wins.
// Ports: req0/req1 requests, last_grant previous winner; gnt_valid any request, gnt_idx winner.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_idx
);

    always_comb begin
        gnt_valid = req0 | req1;
        // A lone requester wins outright; only a tie consults the history bit.
        gnt_idx   = (req0 && req1) ? ~last_grant : req1;
    end

endmodule

// File: rtl/axi_lite_arbiter.sv
// rtl/axi_lite_arbiter.sv - shares one AXI4-Lite master port between two requesters
// Purpose: round-robin arbitration of two single-outstanding req/ack requesters onto AXI4-Lite.
// Ports: clk, reset (sync, active-high);
//        rN_req/we/addr/wdata in, rN_ack/rdata/resp out (N=0,1);
//        m_axi AXI4-Lite master interface.
module axi_lite_arbiter
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_ack,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    output resp_t                 r0_resp,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_ack,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output resp_t                 r1_resp,
    axi_lite_arbiter_if.master    m_axi
);

    state_e                state_q, state_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  ack0_q, ack0_d, ack1_q, ack1_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  gnt_q, gnt_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    resp_t                 resp0_q, resp0_d, resp1_q, resp1_d;
    logic                  arb_valid, arb_idx;

    rr_arb2 u_arb (
        .req0       (r0_req),
        .req1       (r1_req),
        .last_grant (last_q),
        .gnt_valid  (arb_valid),
        .gnt_idx    (arb_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            resp0_q   <= RESP_OKAY;
            resp1_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            resp0_q   <= resp0_d;
            resp1_q   <= resp1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        resp0_d   = resp0_q;
        resp1_d   = resp1_q;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    addr_d  = arb_idx ? r1_addr  : r0_addr;
                    wdata_d = arb_idx ? r1_wdata : r0_wdata;
                    gnt_d   = arb_idx;
                    last_d  = arb_idx;
                    if (arb_idx ? r1_we : r0_we) begin
                        state_d   = WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                // Address and data channels retire independently; each valid
                // falls the cycle after its own handshake.
                awvalid_d = awvalid_q && !m_axi.awready;
                wvalid_d  = wvalid_q && !m_axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WRESP;
                    bready_d = 1'b1;
                end
            end
            WRESP: begin
                if (m_axi.bvalid && bready_q) begin
                    bready_d = 1'b0;
                    state_d  = DONE;
                    if (gnt_q) begin
                        resp1_d = m_axi.bresp;
                        ack1_d  = 1'b1;
                    end else begin
                        resp0_d = m_axi.bresp;
                        ack0_d  = 1'b1;
                    end
                end
            end
            RADDR: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (m_axi.rvalid && rready_q) begin
                    rready_d = 1'b0;
                    state_d  = DONE;
                    if (gnt_q) begin
                        rdata1_d = m_axi.rdata;
                        resp1_d  = m_axi.rresp;
                        ack1_d   = 1'b1;
                    end else begin
                        rdata0_d = m_axi.rdata;
                        resp0_d  = m_axi.rresp;
                        ack0_d   = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    assign r0_ack   = ack0_q;
    assign r1_ack   = ack1_q;
    assign r0_rdata = rdata0_q;
    assign r1_rdata = rdata1_q;
    assign r0_resp  = resp0_q;
    assign r1_resp  = resp1_q;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb/tb_axi_lite_arbiter.sv - self-checking bench for axi_lite_arbiter
module tb_axi_lite_arbiter;
    import axi_lite_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        r_req   [2];
    logic        r_we    [2];
    logic [31:0] r_addr  [2];
    logic [31:0] r_wdata [2];
    logic        ack     [2];
    logic [31:0] rdata   [2];
    logic [1:0]  resp    [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_lite_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axi_lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .r0_req   (r_req[0]),
        .r0_we    (r_we[0]),
        .r0_addr  (r_addr[0]),
        .r0_wdata (r_wdata[0]),
        .r0_ack   (ack[0]),
        .r0_rdata (rdata[0]),
        .r0_resp  (resp[0]),
        .r1_req   (r_req[1]),
        .r1_we    (r_we[1]),
        .r1_addr  (r_addr[1]),
        .r1_wdata (r_wdata[1]),
        .r1_ack   (ack[1]),
        .r1_rdata (rdata[1]),
        .r1_resp  (resp[1]),
        .m_axi    (axi.master)
    );

    // ---------------- slave model with programmable stalls ----------------
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  b_resp_cfg = RESP_OKAY, r_resp_cfg = RESP_OKAY;
    logic [31:0] r_xor = 32'h0;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic        aw_got, w_got, r_got;
    logic [31:0] ar_lat;

    assign axi.awready = axi.awvalid && !aw_got && (aw_cnt >= aw_dly);
    assign axi.wready  = axi.wvalid && !w_got && (w_cnt >= w_dly);
    assign axi.bvalid  = aw_got && w_got && (b_cnt >= b_dly);
    assign axi.bresp   = b_resp_cfg;
    assign axi.arready = axi.arvalid && !r_got && (ar_cnt >= ar_dly);
    assign axi.rvalid  = r_got && (r_cnt >= r_dly);
    assign axi.rdata   = ar_lat ^ r_xor;
    assign axi.rresp   = r_resp_cfg;

    always @(posedge clk) begin
        if (reset) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; r_got <= 1'b0; ar_lat <= 32'h0;
        end else begin
            if (axi.awvalid && axi.awready) begin aw_got <= 1'b1; aw_cnt <= 0; end
            else if (axi.awvalid) aw_cnt <= aw_cnt + 1;
            if (axi.wvalid && axi.wready) begin w_got <= 1'b1; w_cnt <= 0; end
            else if (axi.wvalid) w_cnt <= w_cnt + 1;
            if (axi.bvalid && axi.bready) begin aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0; end
            else if (aw_got && w_got) b_cnt <= b_cnt + 1;
            if (axi.arvalid && axi.arready) begin r_got <= 1'b1; ar_lat <= axi.araddr; ar_cnt <= 0; end
            else if (axi.arvalid) ar_cnt <= ar_cnt + 1;
            if (axi.rvalid && axi.rready) begin r_got <= 1'b0; r_cnt <= 0; end
            else if (r_got) r_cnt <= r_cnt + 1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          idx;
        bit          we;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] exp_rd [2];
    logic [1:0]  exp_rs [2];

    always @(negedge clk) begin
        if (!reset && (ack[0] || ack[1])) begin
            exp_t        it;
            int          gi;
            logic [31:0] er;
            n_checks++;
            if (ack[0] && ack[1]) begin
                n_fail++; $display("FAIL dual_ack: both acks high, required one");
            end
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++; $display("FAIL unexpected_ack: r%0d acked with nothing pending", ack[1] ? 1 : 0);
            end else begin
                it = sb.pop_front();
                gi = ack[1] ? 1 : 0;
                er = it.we ? exp_rd[it.idx] : it.rdata;
                n_checks++;
                if (gi != it.idx) begin
                    n_fail++; $display("FAIL grant_order: acked r%0d, required r%0d", gi, it.idx);
                end
                n_checks++;
                if (rdata[it.idx] !== er) begin
                    n_fail++; $display("FAIL rdata_r%0d: got %h, required %h", it.idx, rdata[it.idx], er);
                end
                n_checks++;
                if (resp[it.idx] !== it.resp) begin
                    n_fail++; $display("FAIL resp_r%0d: got %b, required %b", it.idx, resp[it.idx], it.resp);
                end
                exp_rd[it.idx] = er;
                exp_rs[it.idx] = it.resp;
                n_checks++;
                if (rdata[1-it.idx] !== exp_rd[1-it.idx] || resp[1-it.idx] !== exp_rs[1-it.idx]) begin
                    n_fail++;
                    $display("FAIL other_untouched_r%0d: got %h/%b, required %h/%b", 1 - it.idx,
                             rdata[1-it.idx], resp[1-it.idx], exp_rd[1-it.idx], exp_rs[1-it.idx]);
                end
            end
        end
    end

    // ---------------- per-transaction bus recorder (cycle 0 = req first high) ----------------
    bit          rec_on = 1'b0;
    int          rec_k;
    int          first_aw, first_w, first_ar, aw_hs, w_hs, ar_hs, aw_drop, w_drop, ar_drop;
    int          b_first, r_first, bv_first, ack_at, n_aw, n_w, n_ar, n_b, bad_bready;
    logic [31:0] seen_awaddr, seen_wdata, seen_araddr;
    logic [3:0]  seen_wstrb;
    logic [2:0]  seen_prot;

    task automatic clear_rec();
        rec_k = 0;
        first_aw = -1; first_w = -1; first_ar = -1; aw_hs = -1; w_hs = -1; ar_hs = -1;
        aw_drop = -1; w_drop = -1; ar_drop = -1; b_first = -1; r_first = -1; bv_first = -1;
        ack_at = -1; n_aw = 0; n_w = 0; n_ar = 0; n_b = 0; bad_bready = 0;
        seen_awaddr = 'x; seen_wdata = 'x; seen_araddr = 'x; seen_wstrb = 'x; seen_prot = 'x;
    endtask

    always @(negedge clk) begin
        if (rec_on) begin
            if (axi.awvalid) begin n_aw++; if (first_aw < 0) first_aw = rec_k; end
            if (axi.awvalid && axi.awready) begin aw_hs = rec_k; seen_awaddr = axi.awaddr; seen_prot = axi.awprot; end
            if (aw_hs >= 0 && !axi.awvalid && aw_drop < 0) aw_drop = rec_k;
            if (axi.wvalid) begin n_w++; if (first_w < 0) first_w = rec_k; end
            if (axi.wvalid && axi.wready) begin w_hs = rec_k; seen_wdata = axi.wdata; seen_wstrb = axi.wstrb; end
            if (w_hs >= 0 && !axi.wvalid && w_drop < 0) w_drop = rec_k;
            if (axi.arvalid) begin n_ar++; if (first_ar < 0) first_ar = rec_k; end
            if (axi.arvalid && axi.arready) begin ar_hs = rec_k; seen_araddr = axi.araddr; seen_prot = axi.arprot; end
            if (ar_hs >= 0 && !axi.arvalid && ar_drop < 0) ar_drop = rec_k;
            if (axi.bready) begin n_b++; if (b_first < 0) b_first = rec_k; end
            if (axi.bready && (axi.awvalid || axi.wvalid)) bad_bready++;
            if (axi.bvalid && bv_first < 0) bv_first = rec_k;
            if (axi.rready && r_first < 0) r_first = rec_k;
            if ((ack[0] || ack[1]) && ack_at < 0) ack_at = rec_k;
            rec_k++;
        end
    end

    // Raise req one step after a posedge, hold until ack is seen, drop on the next edge.
    task automatic do_req(input int idx, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input bit rec);
        int k;
        @(posedge clk); #1;
        r_we[idx] = we; r_addr[idx] = addr; r_wdata[idx] = wd; r_req[idx] = 1'b1;
        if (rec) begin clear_rec(); rec_on = 1'b1; end
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            if (ack[idx]) break;
            k++;
        end
        n_checks++;
        if (k >= 200) begin
            n_fail++; $display("FAIL timeout_r%0d: no ack after %0d cycles, required ack", idx, k);
        end
        @(posedge clk); #1;
        r_req[idx] = 1'b0;
        if (rec) rec_on = 1'b0;
    endtask

    task automatic push(input int idx, input bit we, input logic [31:0] rd, input logic [1:0] rs);
        exp_t e;
        e.idx = idx; e.we = we; e.rdata = rd; e.resp = rs;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = 32'h0; r_wdata[i] = 32'h0;
            exp_rd[i] = 32'h0; exp_rs[i] = RESP_OKAY;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++;
        if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 5'b0) begin
            n_fail++; $display("FAIL reset_valids: got %b, required 00000",
                               {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready});
        end
        n_checks++;
        if ({ack[0], ack[1]} !== 2'b00) begin
            n_fail++; $display("FAIL reset_acks: got %b, required 00", {ack[0], ack[1]});
        end
        n_checks++;
        if (rdata[0] !== 32'h0 || rdata[1] !== 32'h0 || resp[0] !== 2'b00 || resp[1] !== 2'b00) begin
            n_fail++; $display("FAIL reset_outputs: got %h %h %b %b, required zeros",
                               rdata[0], rdata[1], resp[0], resp[1]);
        end
    endtask

    task automatic test_write_basic();
        aw_dly = 0; w_dly = 0; b_dly = 0; b_resp_cfg = RESP_OKAY;
        push(0, 1'b1, 32'h0, RESP_OKAY);
        do_req(0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1);
        n_checks++;
        if (first_aw !== 1 || first_w !== 1) begin
            n_fail++; $display("FAIL wr_valid_latency: aw %0d w %0d, required 1 1", first_aw, first_w);
        end
        n_checks++;
        if (b_first !== 2) begin
            n_fail++; $display("FAIL wr_bready_cycle: got %0d, required 2", b_first);
        end
        n_checks++;
        if (ack_at !== 3) begin
            n_fail++; $display("FAIL wr_ack_cycle: got %0d, required 3", ack_at);
        end
        n_checks++;
        if (seen_awaddr !== 32'h0000_1000 || seen_wdata !== 32'hDEAD_BEEF || seen_wstrb !== 4'hF || seen_prot !== 3'b0) begin
            n_fail++; $display("FAIL wr_payload: got %h %h %h %b, required 00001000 deadbeef f 000",
                               seen_awaddr, seen_wdata, seen_wstrb, seen_prot);
        end
    endtask

    task automatic test_read_slverr();
        ar_dly = 0; r_dly = 3; r_resp_cfg = RESP_SLVERR;
        r_xor = 32'hCAFE_F00D ^ 32'h0000_2004;
        push(1, 1'b0, 32'hCAFE_F00D, RESP_SLVERR);
        do_req(1, 1'b0, 32'h0000_2004, 32'h0, 1'b1);
        n_checks++;
        if (first_ar !== 1 || n_ar !== 1) begin
            n_fail++; $display("FAIL rd_arvalid: first %0d count %0d, required 1 1", first_ar, n_ar);
        end
        n_checks++;
        if (r_first !== 2 || seen_araddr !== 32'h0000_2004) begin
            n_fail++; $display("FAIL rd_rready_addr: rready %0d addr %h, required 2 00002004", r_first, seen_araddr);
        end
        n_checks++;
        if (ack_at !== 6) begin
            n_fail++; $display("FAIL rd_ack_cycle: got %0d, required 6", ack_at);
        end
        r_dly = 0; r_resp_cfg = RESP_OKAY;
    endtask

    task automatic test_write_order(input int idx, input int adly, input int wdly);
        int last_hs;
        aw_dly = adly; w_dly = wdly; b_dly = 0; b_resp_cfg = RESP_OKAY;
        push(idx, 1'b1, 32'h0, RESP_OKAY);
        do_req(idx, 1'b1, 32'h0000_3000 + adly, 32'h1234_0000 + wdly, 1'b1);
        last_hs = (adly > wdly) ? 1 + adly : 1 + wdly;
        n_checks++;
        if (aw_hs !== 1 + adly || w_hs !== 1 + wdly) begin
            n_fail++; $display("FAIL order_hs_%0d_%0d: aw %0d w %0d, required %0d %0d",
                               adly, wdly, aw_hs, w_hs, 1 + adly, 1 + wdly);
        end
        n_checks++;
        if (aw_drop !== aw_hs + 1 || w_drop !== w_hs + 1) begin
            n_fail++; $display("FAIL order_drop_%0d_%0d: aw %0d w %0d, required %0d %0d",
                               adly, wdly, aw_drop, w_drop, aw_hs + 1, w_hs + 1);
        end
        n_checks++;
        if (b_first !== last_hs + 1 || bad_bready !== 0) begin
            n_fail++; $display("FAIL order_bready_%0d_%0d: first %0d overlap %0d, required %0d 0",
                               adly, wdly, b_first, bad_bready, last_hs + 1);
        end
        n_checks++;
        if (ack_at !== last_hs + 2) begin
            n_fail++; $display("FAIL order_ack_%0d_%0d: got %0d, required %0d", adly, wdly, ack_at, last_hs + 2);
        end
        aw_dly = 0; w_dly = 0;
    endtask

    task automatic test_bresp_stall();
        b_dly = 10; b_resp_cfg = RESP_DECERR;
        push(1, 1'b1, 32'h0, RESP_DECERR);
        do_req(1, 1'b1, 32'h0000_4000, 32'h5555_AAAA, 1'b1);
        n_checks++;
        if (b_first !== 2 || n_b !== 11) begin
            n_fail++; $display("FAIL stall_bready: first %0d cycles %0d, required 2 11", b_first, n_b);
        end
        n_checks++;
        if (n_aw !== 1 || n_w !== 1 || bv_first !== 12) begin
            n_fail++; $display("FAIL stall_valids: aw %0d w %0d bvalid %0d, required 1 1 12", n_aw, n_w, bv_first);
        end
        n_checks++;
        if (ack_at !== 13) begin
            n_fail++; $display("FAIL stall_ack: got %0d, required 13", ack_at);
        end
        b_dly = 0; b_resp_cfg = RESP_OKAY;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        r_xor = 32'h0F0F_0000;
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, (32'h100 + 4 * i) ^ r_xor, RESP_OKAY);
            push(1, 1'b0, (32'h200 + 4 * i) ^ r_xor, RESP_OKAY);
        end
        fork
            for (int i = 0; i < 4; i++) do_req(0, 1'b0, 32'h100 + 4 * i, 32'h0, 1'b0);
            for (int j = 0; j < 4; j++) do_req(1, 1'b0, 32'h200 + 4 * j, 32'h0, 1'b0);
        join
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++; $display("FAIL b2b_pending: %0d expected acks left, required 0", sb.size());
        end
    endtask

    task automatic test_reset_midflight();
        int k;
        r_dly = 20; r_xor = 32'h0;
        @(posedge clk); #1;
        r_we[0] = 1'b0; r_addr[0] = 32'h0000_5000; r_req[0] = 1'b1;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            if (axi.rready) break;
            k++;
        end
        n_checks++;
        if (k >= 50) begin
            n_fail++; $display("FAIL mid_rready: rready never rose, required high");
        end
        @(posedge clk); #1;
        reset = 1'b1; r_req[0] = 1'b0;
        exp_rd[0] = 32'h0; exp_rs[0] = RESP_OKAY; exp_rd[1] = 32'h0; exp_rs[1] = RESP_OKAY;
        @(posedge clk); #1;
        reset = 1'b0;
        r_dly = 0;
        @(negedge clk);
        n_checks++;
        if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, ack[0], ack[1]} !== 7'b0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %b, required 0000000",
                               {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, ack[0], ack[1]});
        end
        repeat (4) @(negedge clk);
        b_resp_cfg = RESP_OKAY;
        push(0, 1'b1, 32'h0, RESP_OKAY);
        do_req(0, 1'b1, 32'h0000_6000, 32'h0BAD_F00D, 1'b1);
        n_checks++;
        if (ack_at !== 3 || seen_awaddr !== 32'h0000_6000) begin
            n_fail++; $display("FAIL mid_recover: ack %0d addr %h, required 3 00006000", ack_at, seen_awaddr);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = 32'h0; r_wdata[i] = 32'h0;
            exp_rd[i] = 32'h0; exp_rs[i] = RESP_OKAY;
        end
        test_reset();
        test_write_basic();
        test_read_slverr();
        test_write_order(1, 5, 0);
        test_write_order(0, 0, 5);
        test_bresp_stall();
        test_back_to_back();
        test_reset_midflight();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++; $display("FAIL final_pending: %0d expected acks left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
